dma_reg_bank: RTL and testbench

- Parametrised multi-channel DMA control/status register bank on the team's simple register bus (wr_en/rd_en/addr/wdata/rdata), extended with a read-valid handshake, a configurable read latency and an error response.
- Sits between the register-bus driver and the DMA transfer engine.
- Exports per-channel configuration and start pulses to the engine, and collects done/error/busy status back from it.
- Drives a level interrupt.

---
 rtl/dma_reg_pkg.sv | 31 +++
 rtl/dma_ch_regs.sv | 118 +++++++++++
 rtl/dma_reg_bank.sv | 141 ++++++++++++++
 tb/tb_dma_reg_bank.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_reg_pkg.sv
// rtl/dma_reg_pkg.sv - shared offsets, bit positions and decode types for the DMA register bank
package dma_reg_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_SRC    = 5'h04;
    localparam logic [4:0] OFF_DST    = 5'h08;
    localparam logic [4:0] OFF_LEN    = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;

    localparam int GLB_OFF_IRQ = 'h0;
    localparam int GLB_OFF_ID  = 'h4;

    localparam int CTRL_START    = 0;
    localparam int CTRL_IE       = 1;
    localparam int CTRL_MODE     = 2;
    localparam int CTRL_PRIO_LSB = 4;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    localparam logic [31:0] ID_BASE  = 32'hD3A0_0000;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        CH_REG,
        GLB_REG,
        UNMAPPED
    } dec_kind_e;

endpackage

// File: rtl/dma_ch_regs.sv
// rtl/dma_ch_regs.sv - one DMA channel: CTRL/SRC/DST/LEN/STATUS, start pulse, W1C status, circular restart
module dma_ch_regs
    import dma_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_i,
    input  logic [4:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic        busy_i,
    input  logic        done_i,
    input  logic        err_i,
    output logic [31:0] rdata_o,
    output logic        start_o,
    output logic [31:0] src_o,
    output logic [31:0] dst_o,
    output logic [15:0] len_o,
    output logic        mode_o,
    output logic        irq_o
);

    logic        ie_q, ie_d;
    logic        mode_q, mode_d;
    logic [3:0]  prio_q, prio_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        start_q, start_d;

    always_comb begin
        ie_d    = ie_q;
        mode_d  = mode_q;
        prio_d  = prio_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        done_d  = done_q | done_i;
        err_d   = err_q | err_i;
        start_d = 1'b0;
        if (wr_i) begin
            case (off_i)
                OFF_CTRL: begin
                    ie_d   = wdata_i[CTRL_IE];
                    mode_d = wdata_i[CTRL_MODE];
                    prio_d = wdata_i[CTRL_PRIO_LSB +: 4];
                    if (wdata_i[CTRL_START]) begin
                        if (busy_i) err_d = 1'b1;
                        else        start_d = 1'b1;
                    end
                end
                OFF_SRC: src_d = wdata_i;
                OFF_DST: dst_d = wdata_i;
                OFF_LEN: len_d = wdata_i[15:0];
                OFF_STATUS: begin
                    // a same-cycle engine pulse beats the clear
                    if (wdata_i[ST_DONE]) done_d = done_i;
                    if (wdata_i[ST_ERR])  err_d  = err_i;
                end
                default: ;
            endcase
        end
        if (done_i && mode_q && ie_q && !err_d) start_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q    <= 1'b0;
            mode_q  <= 1'b0;
            prio_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            ie_q    <= ie_d;
            mode_q  <= mode_d;
            prio_q  <= prio_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (off_i)
            OFF_CTRL: begin
                rdata_o[CTRL_IE]            = ie_q;
                rdata_o[CTRL_MODE]          = mode_q;
                rdata_o[CTRL_PRIO_LSB +: 4] = prio_q;
            end
            OFF_SRC: rdata_o = src_q;
            OFF_DST: rdata_o = dst_q;
            OFF_LEN: rdata_o[15:0] = len_q;
            OFF_STATUS: begin
                rdata_o[ST_BUSY] = busy_i;
                rdata_o[ST_DONE] = done_q;
                rdata_o[ST_ERR]  = err_q;
            end
            default: ;
        endcase
    end

    assign start_o = start_q;
    assign src_o   = src_q;
    assign dst_o   = dst_q;
    assign len_o   = len_q;
    assign mode_o  = mode_q;
    assign irq_o   = ie_q & (done_q | err_q);

endmodule

// File: rtl/dma_reg_bank.sv
// rtl/dma_reg_bank.sv - multi-channel DMA register bank: decode, channel array, read pipeline, irq
module dma_reg_bank
    import dma_reg_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int CH_STRIDE = 'h20,
    parameter int GLB_BASE  = 'h100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata,
    output logic                 rd_valid,
    output logic                 bus_err,
    output logic [NUM_CH-1:0]    ch_start,
    output logic [NUM_CH*32-1:0] ch_src,
    output logic [NUM_CH*32-1:0] ch_dst,
    output logic [NUM_CH*16-1:0] ch_len,
    output logic [NUM_CH-1:0]    ch_mode,
    input  logic [NUM_CH-1:0]    eng_busy,
    input  logic [NUM_CH-1:0]    eng_done,
    input  logic [NUM_CH-1:0]    eng_err,
    output logic                 irq
);

    dec_kind_e          dec_kind;
    logic [NUM_CH-1:0]  dec_sel;
    logic [4:0]         dec_off;
    logic               dec_is_id;
    logic [ADDR_W-1:0]  ch_off;
    logic [DATA_W-1:0]  rd_data;
    logic               rd_err;
    logic [31:0]        ch_rdata [NUM_CH];
    logic [NUM_CH-1:0]  irq_stat;

    logic [RD_LAT-1:0]  pv_q;
    logic [RD_LAT-1:0]  pe_q;
    logic [DATA_W-1:0]  pd_q [RD_LAT];
    logic               wr_err_q;
    logic               irq_q;

    // Misaligned addresses fall through to UNMAPPED so reads and writes share one error path.
    always_comb begin
        dec_kind  = UNMAPPED;
        dec_sel   = '0;
        dec_off   = '0;
        dec_is_id = 1'b0;
        ch_off    = '0;
        if (addr[1:0] == 2'b00) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ch_off = addr - ADDR_W'(c * CH_STRIDE);
                if (addr >= ADDR_W'(c * CH_STRIDE) && ch_off <= ADDR_W'(OFF_STATUS)) begin
                    dec_kind   = CH_REG;
                    dec_sel[c] = 1'b1;
                    dec_off    = ch_off[4:0];
                end
            end
            if (addr == ADDR_W'(GLB_BASE + GLB_OFF_IRQ)) begin
                dec_kind = GLB_REG;
            end else if (addr == ADDR_W'(GLB_BASE + GLB_OFF_ID)) begin
                dec_kind  = GLB_REG;
                dec_is_id = 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dma_ch_regs u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_i    (wr_en && dec_kind == CH_REG && dec_sel[c]),
            .off_i   (dec_off),
            .wdata_i (wdata),
            .busy_i  (eng_busy[c]),
            .done_i  (eng_done[c]),
            .err_i   (eng_err[c]),
            .rdata_o (ch_rdata[c]),
            .start_o (ch_start[c]),
            .src_o   (ch_src[c*32 +: 32]),
            .dst_o   (ch_dst[c*32 +: 32]),
            .len_o   (ch_len[c*16 +: 16]),
            .mode_o  (ch_mode[c]),
            .irq_o   (irq_stat[c])
        );
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (dec_kind)
            CH_REG: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (dec_sel[c]) rd_data = ch_rdata[c];
                end
            end
            GLB_REG: rd_data = dec_is_id ? (ID_BASE | 32'(NUM_CH)) : 32'(irq_stat);
            default: begin
                rd_data = ERR_DATA;
                rd_err  = 1'b1;
            end
        endcase
    end

    // Read data is captured at the rd_en edge, so a same-edge write is not yet visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q     <= '0;
            pe_q     <= '0;
            for (int i = 0; i < RD_LAT; i++) pd_q[i] <= '0;
            wr_err_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            pv_q[0] <= rd_en;
            if (rd_en) begin
                pd_q[0] <= rd_data;
                pe_q[0] <= rd_err;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                if (pv_q[i-1]) begin
                    pd_q[i] <= pd_q[i-1];
                    pe_q[i] <= pe_q[i-1];
                end
            end
            wr_err_q <= wr_en && (dec_kind == UNMAPPED);
            irq_q    <= |irq_stat;
        end
    end

    assign rdata    = pd_q[RD_LAT-1];
    assign rd_valid = pv_q[RD_LAT-1];
    assign bus_err  = wr_err_q | (pv_q[RD_LAT-1] & pe_q[RD_LAT-1]);
    assign irq      = irq_q;

endmodule

// File: tb/tb_dma_reg_bank.sv
// tb/tb_dma_reg_bank.sv - directed scoreboard bench for dma_reg_bank (NUM_CH=4, RD_LAT=2)
module tb_dma_reg_bank;

    localparam int NUM_CH = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wr_en = 1'b0;
    logic                 rd_en = 1'b0;
    logic [31:0]          addr = '0;
    logic [31:0]          wdata = '0;
    logic [31:0]          rdata;
    logic                 rd_valid;
    logic                 bus_err;
    logic [NUM_CH-1:0]    ch_start;
    logic [NUM_CH*32-1:0] ch_src;
    logic [NUM_CH*32-1:0] ch_dst;
    logic [NUM_CH*16-1:0] ch_len;
    logic [NUM_CH-1:0]    ch_mode;
    logic [NUM_CH-1:0]    eng_busy = '0;
    logic [NUM_CH-1:0]    eng_done = '0;
    logic [NUM_CH-1:0]    eng_err = '0;
    logic                 irq;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   rv_count = 0;
    int   rv_mark;

    dma_reg_bank #(
        .NUM_CH    (NUM_CH),
        .ADDR_W    (32),
        .DATA_W    (32),
        .RD_LAT    (2),
        .CH_STRIDE ('h20),
        .GLB_BASE  ('h100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .bus_err  (bus_err),
        .ch_start (ch_start),
        .ch_src   (ch_src),
        .ch_dst   (ch_dst),
        .ch_len   (ch_len),
        .ch_mode  (ch_mode),
        .eng_busy (eng_busy),
        .eng_done (eng_done),
        .eng_err  (eng_err),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] d, input logic e, input bit track);
        rd_en = 1'b1;
        addr  = a;
        if (track) exp_q.push_back('{data: d, err: e});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            exp_t e;
            rv_count++;
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_rd_valid observed=%h expected=no_read_pending", rdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rd_data", rdata, e.data);
                chk("rd_err", 32'(bus_err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_ch_start", 32'(ch_start), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        tick();

        // ID read with two-cycle latency
        bus_read(32'h104, 32'hD3A0_0004, 1'b0, 1'b1);
        chk("id_lat_early", 32'(rd_valid), 32'h0);
        tick();
        chk("id_lat_valid", 32'(rd_valid), 32'h1);
        wait_drain();
        tick();
        chk("rdata_hold", rdata, 32'hD3A0_0004);

        // SRC and LEN on channel 1
        bus_write(32'h24, 32'h1000_0000);
        bus_write(32'h2C, 32'h0001_0040);
        chk("ch_src1", ch_src[63:32], 32'h1000_0000);
        chk("ch_len1", 32'(ch_len[31:16]), 32'h40);
        bus_read(32'h24, 32'h1000_0000, 1'b0, 1'b1);
        bus_read(32'h2C, 32'h0000_0040, 1'b0, 1'b1);
        wait_drain();

        // START on idle and busy channel 0
        bus_write(32'h00, 32'h3);
        chk("start_pulse", 32'(ch_start), 32'h1);
        tick();
        chk("start_one_cycle", 32'(ch_start), 32'h0);
        bus_read(32'h00, 32'h2, 1'b0, 1'b1);
        eng_busy = 4'b0001;
        bus_write(32'h00, 32'h3);
        chk("busy_no_start", 32'(ch_start), 32'h0);
        tick();
        chk("busy_no_start2", 32'(ch_start), 32'h0);
        bus_read(32'h10, 32'h5, 1'b0, 1'b1);
        wait_drain();
        eng_busy = 4'b0000;
        bus_write(32'h10, 32'h4);
        tick();
        tick();
        chk("irq_clear_ch0", 32'(irq), 32'h0);

        // DONE/irq on channel 2, W1C collision
        bus_write(32'h40, 32'h2);
        eng_done = 4'b0100;
        tick();
        eng_done = 4'b0000;
        chk("irq_lag", 32'(irq), 32'h0);
        tick();
        chk("irq_set", 32'(irq), 32'h1);
        bus_read(32'h50, 32'h2, 1'b0, 1'b1);
        eng_done = 4'b0100;
        bus_write(32'h50, 32'h2);
        eng_done = 4'b0000;
        bus_read(32'h50, 32'h2, 1'b0, 1'b1);
        chk("irq_after_collision", 32'(irq), 32'h1);
        bus_write(32'h50, 32'h2);
        tick();
        chk("irq_w1c", 32'(irq), 32'h0);
        bus_read(32'h50, 32'h0, 1'b0, 1'b1);
        wait_drain();

        // circular mode on channel 3
        bus_write(32'h60, 32'h6);
        chk("ch_mode3", 32'(ch_mode), 32'h8);
        bus_write(32'h60, 32'h7);
        chk("ch3_start", 32'(ch_start), 32'h8);
        tick();
        chk("ch3_start_end", 32'(ch_start), 32'h0);
        eng_done = 4'b1000;
        tick();
        eng_done = 4'b0000;
        chk("circ_restart", 32'(ch_start), 32'h8);
        tick();
        chk("circ_restart_end", 32'(ch_start), 32'h0);
        eng_err = 4'b1000;
        tick();
        eng_err = 4'b0000;
        eng_done = 4'b1000;
        tick();
        eng_done = 4'b0000;
        chk("circ_err_no_restart", 32'(ch_start), 32'h0);
        bus_read(32'h70, 32'h6, 1'b0, 1'b1);
        wait_drain();

        // write error responses
        bus_write(32'h0FC, 32'h1);
        chk("wr_unmapped_err", 32'(bus_err), 32'h1);
        tick();
        chk("wr_err_one_cycle", 32'(bus_err), 32'h0);
        bus_write(32'h104, 32'h0);
        chk("wr_ro_no_err", 32'(bus_err), 32'h0);
        bus_write(32'h002, 32'h1);
        chk("wr_misaligned_err", 32'(bus_err), 32'h1);
        chk("misaligned_no_start", 32'(ch_start), 32'h0);

        // back-to-back reads including errors
        rv_mark = rv_count;
        bus_read(32'h000, 32'h2, 1'b0, 1'b1);
        bus_read(32'h0FC, 32'hDEAD_BEEF, 1'b1, 1'b1);
        bus_read(32'h002, 32'hDEAD_BEEF, 1'b1, 1'b1);
        bus_read(32'h104, 32'hD3A0_0004, 1'b0, 1'b1);
        wait_drain();
        chk("b2b_count", 32'(rv_count - rv_mark), 32'd4);

        // reset with reads in flight
        rv_mark = rv_count;
        bus_read(32'h024, 32'h1000_0000, 1'b0, 1'b1);
        bus_read(32'h104, 32'hD3A0_0004, 1'b0, 1'b0);
        bus_read(32'h000, 32'h2, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("rst_flush_count", 32'(rv_count - rv_mark), 32'd1);
        chk("rst_flush_queue", 32'(exp_q.size()), 32'd0);
        chk("rst_ch_src1", ch_src[63:32], 32'h0);
        chk("rst_irq_mid", 32'(irq), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
